// File: rtl/iterative_shift_sequencer.sv
// ============================================================================
// Module      : iterative_shift_sequencer
// Description : Multi-cycle logical-left / arithmetic-right shifter that applies
//               one power-of-two stage per clock, MSB stage first, behind
//               valid/ready handshakes. Optional macro SHIFT_EARLY_EXIT_EN ends
//               the sequence once no lower shift-amount bits remain set.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module iterative_shift_sequencer #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   data_in,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic               dir,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   result,
    output logic               busy
);

    localparam int IDX_W = (SHAMT_W > 1) ? $clog2(SHAMT_W) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   op_q, op_d;
    logic [SHAMT_W-1:0] amt_q, amt_d;
    logic               dir_q, dir_d;
    logic [IDX_W-1:0]   stage_idx_q, stage_idx_d;

    logic [WIDTH-1:0]   w_step;
    logic               w_last;

    assign w_step = WIDTH'(1) << stage_idx_q;

    // Decide whether the stage being processed this cycle is the final one.
`ifdef SHIFT_EARLY_EXIT_EN
    logic [SHAMT_W-1:0] w_low_mask;
    assign w_low_mask = (SHAMT_W'(1) << stage_idx_q) - SHAMT_W'(1);
    assign w_last     = (stage_idx_q == '0) || ((amt_q & w_low_mask) == '0);
`else
    assign w_last     = (stage_idx_q == '0);
`endif

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        amt_d       = amt_q;
        dir_d       = dir_q;
        stage_idx_d = stage_idx_q;

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    op_d        = data_in;
                    amt_d       = shamt;
                    dir_d       = dir;
                    stage_idx_d = IDX_W'(SHAMT_W - 1);
                    state_d     = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                // Each right stage copies the current MSB, which is still the original sign.
                if (amt_q[stage_idx_q]) begin
                    if (dir_q) begin
                        op_d = WIDTH'($signed(op_q) >>> w_step);
                    end else begin
                        op_d = op_q << w_step;
                    end
                end
                if (w_last) begin
                    state_d = ST_DONE;
                end else begin
                    stage_idx_d = stage_idx_q - IDX_W'(1);
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            op_q        <= '0;
            amt_q       <= '0;
            dir_q       <= 1'b0;
            stage_idx_q <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            amt_q       <= amt_d;
            dir_q       <= dir_d;
            stage_idx_q <= stage_idx_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign busy      = (state_q != ST_IDLE);
    assign result    = op_q;

endmodule

`default_nettype wire
